bnn_image_feeder: RTL and testbench
===================================

Name: bnn_image_feeder

Overview:
Synthesizable successor to the bench-side pixel streamer that drives CNN_top. It holds NUM_SLOTS image buffers loaded by a host port, and streams one pixel per din_ready request into the CNN. It drives start until conv1_done, then captures the class vector on done. Slots are served round-robin, so the host can load one image while another is being classified. It sits between the host/DMA interface and CNN_top.

Parameters:
DATA_W, 32, pixel word width (signed, passed through unmodified)
IMG_PIXELS, 784, pixels per image
NUM_SLOTS, 2, number of image buffers (>=1)
CLASS_W, 10, width of CNN class vector
SLOT_W, $clog2(NUM_SLOTS) min 1, slot index width
ADDR_W, $clog2(IMG_PIXELS), pixel address width

Ports:
clk  in  1  clock
rstn  in  1  reset
wr_en  in  1  host pixel write strobe
wr_slot  in  SLOT_W  target slot
wr_addr  in  ADDR_W  pixel index
wr_data  in  DATA_W  pixel value
load_done  in  1  pulse: slot wr_slot fully loaded, mark full
slot_full  out  NUM_SLOTS  per-slot loaded flag
cnn_start  out  1  start to CNN
cnn_din  out  DATA_W  pixel to CNN
cnn_din_ready  in  1  CNN requests next pixel
cnn_conv1_done  in  1  CNN finished first layer
cnn_done  in  1  CNN classification complete
cnn_classes  in  CLASS_W  CNN class vector
res_valid  out  1  one-cycle result strobe
res_slot  out  SLOT_W  slot the result belongs to
res_classes  out  CLASS_W  captured class vector
res_idx  out  4  index of lowest set bit of res_classes; res_none when zero
res_none  out  1  captured vector was all-zero
res_short  out  1  done arrived before IMG_PIXELS pixels were sent
busy  out  1  state != IDLE
err_underrun  out  1  sticky: din_ready with no pixels remaining
err_wr_busy  out  1  sticky: write/load_done targeted the active or already-full slot

Behaviour:
- Single clock clk. Reset rstn is synchronous and active-low.
- Reset, including mid-operation: state IDLE, all slot_full=0, every output 0, pixel count 0, next-slot pointer 0. Buffer contents are don't-care.
- FSM:
  - IDLE -> STREAM when any slot is full. Pick the first full slot at or after the pointer, wrapping.
  - STREAM -> WAIT_DONE when cnn_conv1_done is sampled high.
  - WAIT_DONE -> RESULT on cnn_done.
  - RESULT (1 cycle) -> IDLE.
- cnn_start = (state==STREAM) && !cnn_conv1_done. It is the only combinational output; it drops in the same cycle conv1_done rises.
- Pixel feed, 1-cycle latency: on a clock edge with cnn_din_ready=1 in STREAM and cnt<IMG_PIXELS, register cnn_din <= buf[slot][cnt] and increment cnt. Pixel k appears on cnn_din the cycle after the k-th request and holds until the next request.
- cnn_din_ready in STREAM with cnt==IMG_PIXELS: cnn_din holds, cnt holds, err_underrun set. Requests outside STREAM are ignored.
- cnn_done seen in STREAM before conv1_done: go directly to RESULT.
- RESULT cycle:
  - res_valid=1.
  - res_classes and res_slot registered; they hold until the next RESULT.
  - res_idx = lowest set bit index; res_none = vector zero.
  - res_short = (cnt<IMG_PIXELS).
  - Clear slot_full[slot], advance pointer to slot+1 mod NUM_SLOTS, reset cnt to 0.
- Host writes: accepted when slot_full[wr_slot]==0 and wr_slot is not the active slot. Otherwise the write is dropped and err_wr_busy is set.
- load_done: sets slot_full[wr_slot] if it is clear and not active, else sets err_wr_busy.
- load_done and RESULT clearing the same slot in the same cycle: the clear wins and err_wr_busy is set.
- wr_addr >= IMG_PIXELS: dropped silently.
- Sticky errors clear only on reset.

Decomposition:
- Package bnn_feeder_pkg holds the FSM state enum (IDLE, STREAM, WAIT_DONE, RESULT) and the lowest-set-bit function used for res_idx.
- One sub-module, bnn_slot_buffer: NUM_SLOTS*IMG_PIXELS x DATA_W simple dual-port RAM with a synchronous read and a write port.
- The top holds the FSM, counters and pointer.

Test Plan:
- Load slot0 with pixel i = i (0..783), then load_done. CNN model raises din_ready for 784 cycles, then conv1_done, then done with classes=10'b0000100000. Required: cnn_din sequence 0..783, each one cycle after its request; cnn_start low the cycle conv1_done rises; res_valid once, res_idx=5, res_slot=0, res_short=0.
- Load slot0 and slot1, run two images back-to-back. Required: results in slot order 0 then 1, and slot_full returns to 00.
- While slot0 streams, write slot1 and also attempt a write to slot0. Required: the slot1 data is correct when it streams; the slot0 contents are unchanged and err_wr_busy=1.
- Issue an 785th din_ready. Required: cnn_din holds pixel 783 and err_underrun=1.
- Assert done after 100 pixels with classes=0. Required: res_short=1, res_none=1, FSM returns to IDLE.
- Drive rstn low for 1 cycle mid-STREAM. Required: busy=0, slot_full=0 and all outputs 0 on the next cycle; a fresh load then streams from pixel 0.

Source files
------------

// File: rtl/bnn_image_feeder_pkg.sv
// Shared types for the BNN image feeder: FSM state encoding and class-vector decode.
// Pure declarations; no logic or latency of its own.
package bnn_feeder_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        STREAM    = 2'd1,
        WAIT_DONE = 2'd2,
        RESULT    = 2'd3
    } state_t;

    localparam int LSB_IN_W = 16;

    // Index of the lowest set bit; 0 when the vector is all-zero.
    function automatic logic [3:0] lowest_set(input logic [LSB_IN_W-1:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int i = LSB_IN_W - 1; i >= 0; i--) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/bnn_image_feeder_if.sv
// Host-load, CNN-stream and result signals of the image feeder, bundled as one port.
// Master side is the host/CNN environment, slave side is the feeder.
interface bnn_image_feeder_if #(
    parameter int DATA_W    = 32,
    parameter int NUM_SLOTS = 2,
    parameter int CLASS_W   = 10,
    parameter int SLOT_W    = 1,
    parameter int ADDR_W    = 10
);
    logic                 wr_en;
    logic [SLOT_W-1:0]    wr_slot;
    logic [ADDR_W-1:0]    wr_addr;
    logic [DATA_W-1:0]    wr_data;
    logic                 load_done;
    logic [NUM_SLOTS-1:0] slot_full;
    logic                 cnn_start;
    logic [DATA_W-1:0]    cnn_din;
    logic                 cnn_din_ready;
    logic                 cnn_conv1_done;
    logic                 cnn_done;
    logic [CLASS_W-1:0]   cnn_classes;
    logic                 res_valid;
    logic [SLOT_W-1:0]    res_slot;
    logic [CLASS_W-1:0]   res_classes;
    logic [3:0]           res_idx;
    logic                 res_none;
    logic                 res_short;
    logic                 busy;
    logic                 err_underrun;
    logic                 err_wr_busy;

    modport slave (
        input  wr_en, wr_slot, wr_addr, wr_data, load_done,
        input  cnn_din_ready, cnn_conv1_done, cnn_done, cnn_classes,
        output slot_full, cnn_start, cnn_din,
        output res_valid, res_slot, res_classes, res_idx, res_none, res_short,
        output busy, err_underrun, err_wr_busy
    );

    modport master (
        output wr_en, wr_slot, wr_addr, wr_data, load_done,
        output cnn_din_ready, cnn_conv1_done, cnn_done, cnn_classes,
        input  slot_full, cnn_start, cnn_din,
        input  res_valid, res_slot, res_classes, res_idx, res_none, res_short,
        input  busy, err_underrun, err_wr_busy
    );

endinterface

// File: rtl/bnn_slot_buffer.sv
// Image storage for all slots: one write port, one synchronous read port.
// Read data appears one cycle after re and holds while re is low; no backpressure.
module bnn_slot_buffer #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1568,
    parameter int AW     = 11
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Only the output register is reset so cnn_din reads 0 after reset.
    always_ff @(posedge clk) begin
        if (!rstn)   rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/bnn_image_feeder.sv
// Round-robin multi-slot image buffer feeding CNN_top one pixel per din_ready, then capturing the class result.
// Pixel out 1 cycle after each request; host writes to busy/full slots are dropped and flagged, never stalled.
module bnn_image_feeder
    import bnn_feeder_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int IMG_PIXELS = 784,
    parameter int NUM_SLOTS  = 2,
    parameter int CLASS_W    = 10,
    parameter int SLOT_W     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
    parameter int ADDR_W     = $clog2(IMG_PIXELS)
) (
    input  logic clk,
    input  logic rstn,
    bnn_image_feeder_if.slave bus
);

    localparam int CNT_W  = $clog2(IMG_PIXELS + 1);
    localparam int DEPTH  = NUM_SLOTS * IMG_PIXELS;
    localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] PIX_N = CNT_W'(IMG_PIXELS);

    state_t               state, state_nxt;
    logic [SLOT_W-1:0]    cur_slot;
    logic [SLOT_W-1:0]    ptr;
    logic [CNT_W-1:0]     cnt;
    logic [NUM_SLOTS-1:0] slot_full;
    logic                 busy_q;
    logic                 res_valid_q;
    logic [SLOT_W-1:0]    res_slot_q;
    logic [CLASS_W-1:0]   res_classes_q;
    logic [3:0]           res_idx_q;
    logic                 res_none_q;
    logic                 res_short_q;
    logic                 err_underrun_q;
    logic                 err_wr_busy_q;

    logic                 pick_vld;
    logic [SLOT_W-1:0]    pick_slot;
    int                   pick_idx;
    logic                 feed;
    logic                 underrun;
    logic                 wr_blocked;
    logic                 wr_ok;
    logic                 ld_ok;
    logic                 wr_err;
    logic [RAM_AW-1:0]    raddr;
    logic [RAM_AW-1:0]    waddr;

    // First full slot at or after the round-robin pointer.
    always_comb begin
        pick_vld  = 1'b0;
        pick_slot = '0;
        pick_idx  = 0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            pick_idx = (int'(ptr) + i) % NUM_SLOTS;
            if (!pick_vld && slot_full[pick_idx]) begin
                pick_vld  = 1'b1;
                pick_slot = SLOT_W'(pick_idx);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (pick_vld) state_nxt = STREAM;
            STREAM: begin
                if (bus.cnn_done)            state_nxt = RESULT;
                else if (bus.cnn_conv1_done) state_nxt = WAIT_DONE;
            end
            WAIT_DONE: if (bus.cnn_done) state_nxt = RESULT;
            RESULT:    state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        feed       = (state == STREAM) && bus.cnn_din_ready && (cnt < PIX_N);
        underrun   = (state == STREAM) && bus.cnn_din_ready && (cnt >= PIX_N);
        // The slot being served stays write-protected through RESULT, so a
        // load_done racing the clear of that slot is rejected.
        wr_blocked = slot_full[bus.wr_slot] || ((state != IDLE) && (bus.wr_slot == cur_slot));
        wr_ok      = bus.wr_en && !wr_blocked && (32'(bus.wr_addr) < IMG_PIXELS);
        ld_ok      = bus.load_done && !wr_blocked;
        wr_err     = (bus.wr_en || bus.load_done) && wr_blocked;
        raddr      = RAM_AW'(int'(cur_slot) * IMG_PIXELS + int'(cnt));
        waddr      = RAM_AW'(int'(bus.wr_slot) * IMG_PIXELS + int'(bus.wr_addr));
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state          <= IDLE;
            cur_slot       <= '0;
            ptr            <= '0;
            cnt            <= '0;
            slot_full      <= '0;
            busy_q         <= 1'b0;
            res_valid_q    <= 1'b0;
            res_slot_q     <= '0;
            res_classes_q  <= '0;
            res_idx_q      <= '0;
            res_none_q     <= 1'b0;
            res_short_q    <= 1'b0;
            err_underrun_q <= 1'b0;
            err_wr_busy_q  <= 1'b0;
        end else begin
            state       <= state_nxt;
            busy_q      <= (state_nxt != IDLE);
            res_valid_q <= (state_nxt == RESULT);

            if (state == IDLE && pick_vld) begin
                cur_slot <= pick_slot;
                cnt      <= '0;
            end
            if (feed)     cnt            <= cnt + 1'b1;
            if (underrun) err_underrun_q <= 1'b1;
            if (wr_err)   err_wr_busy_q  <= 1'b1;

            if (state != RESULT && state_nxt == RESULT) begin
                res_slot_q    <= cur_slot;
                res_classes_q <= bus.cnn_classes;
                res_idx_q     <= lowest_set(LSB_IN_W'(bus.cnn_classes));
                res_none_q    <= (bus.cnn_classes == '0);
                res_short_q   <= (cnt < PIX_N);
            end

            if (ld_ok) slot_full[bus.wr_slot] <= 1'b1;
            if (state == RESULT) begin
                slot_full[cur_slot] <= 1'b0;
                ptr <= (int'(cur_slot) == NUM_SLOTS - 1) ? '0 : cur_slot + 1'b1;
                cnt <= '0;
            end
        end
    end

    bnn_slot_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (RAM_AW)
    ) u_buf (
        .clk   (clk),
        .rstn  (rstn),
        .we    (wr_ok),
        .waddr (waddr),
        .wdata (bus.wr_data),
        .re    (feed),
        .raddr (raddr),
        .rdata (bus.cnn_din)
    );

    assign bus.cnn_start    = (state == STREAM) && !bus.cnn_conv1_done;
    assign bus.slot_full    = slot_full;
    assign bus.busy         = busy_q;
    assign bus.res_valid    = res_valid_q;
    assign bus.res_slot     = res_slot_q;
    assign bus.res_classes  = res_classes_q;
    assign bus.res_idx      = res_idx_q;
    assign bus.res_none     = res_none_q;
    assign bus.res_short    = res_short_q;
    assign bus.err_underrun = err_underrun_q;
    assign bus.err_wr_busy  = err_wr_busy_q;

endmodule

// File: tb/tb_bnn_image_feeder.sv
// Directed bench for bnn_image_feeder: host loads, pixel streaming, results, errors and reset.
module tb_bnn_image_feeder;

    localparam int DW = 32;
    localparam int NP = 784;
    localparam int NS = 2;
    localparam int CW = 10;
    localparam int SW = 1;
    localparam int AW = 10;

    logic clk;
    logic rstn;
    int   n_tests;
    int   n_fail;

    bnn_image_feeder_if #(
        .DATA_W(DW), .NUM_SLOTS(NS), .CLASS_W(CW), .SLOT_W(SW), .ADDR_W(AW)
    ) bus ();

    bnn_image_feeder #(
        .DATA_W(DW), .IMG_PIXELS(NP), .NUM_SLOTS(NS), .CLASS_W(CW), .SLOT_W(SW), .ADDR_W(AW)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_px(input int s, input int n, input int base);
        for (int i = 0; i < n; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_slot = SW'(s);
            bus.wr_addr = AW'(i);
            bus.wr_data = DW'(base + i);
            tick();
        end
        bus.wr_en = 1'b0;
    endtask

    task automatic mark_full(input int s);
        bus.load_done = 1'b1;
        bus.wr_slot   = SW'(s);
        tick();
        bus.load_done = 1'b0;
    endtask

    task automatic stream_px(input int n, input int base, input bit par_wr, input int par_base, input bit gap);
        for (int k = 0; k < n; k++) begin
            bus.cnn_din_ready = 1'b1;
            if (par_wr) begin
                bus.wr_en   = 1'b1;
                bus.wr_slot = SW'(1);
                bus.wr_addr = AW'(k);
                bus.wr_data = DW'(par_base + k);
            end
            tick();
            check_val("pixel", bus.cnn_din, DW'(base + k));
            if (gap && k == 100) begin
                bus.cnn_din_ready = 1'b0;
                bus.wr_en = 1'b0;
                tick();
                check_val("pixel_hold", bus.cnn_din, DW'(base + k));
            end
        end
        bus.cnn_din_ready = 1'b0;
        bus.wr_en = 1'b0;
    endtask

    task automatic finish_img(input logic [CW-1:0] cls, input int e_slot, input int e_idx,
                              input int e_none, input int e_short, input bit via_conv1);
        check_val("start_hi", bus.cnn_start, 1);
        if (via_conv1) begin
            bus.cnn_conv1_done = 1'b1;
            #1;
            check_val("start_drop", bus.cnn_start, 0);
            tick();
            bus.cnn_conv1_done = 1'b0;
            check_val("wait_busy", bus.busy, 1);
        end
        bus.cnn_done    = 1'b1;
        bus.cnn_classes = cls;
        tick();
        bus.cnn_done    = 1'b0;
        bus.cnn_classes = '0;
        check_val("res_valid", bus.res_valid, 1);
        check_val("res_slot", bus.res_slot, e_slot);
        check_val("res_classes", bus.res_classes, cls);
        check_val("res_idx", bus.res_idx, e_idx);
        check_val("res_none", bus.res_none, e_none);
        check_val("res_short", bus.res_short, e_short);
        tick();
        check_val("res_valid_pulse", bus.res_valid, 0);
        check_val("res_hold", bus.res_classes, cls);
        check_val("idle_busy", bus.busy, 0);
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, "_busy"}, bus.busy, 0);
        check_val({tag, "_full"}, bus.slot_full, 0);
        check_val({tag, "_start"}, bus.cnn_start, 0);
        check_val({tag, "_din"}, bus.cnn_din, 0);
        check_val({tag, "_rvalid"}, bus.res_valid, 0);
        check_val({tag, "_rslot"}, bus.res_slot, 0);
        check_val({tag, "_rcls"}, bus.res_classes, 0);
        check_val({tag, "_ridx"}, bus.res_idx, 0);
        check_val({tag, "_rnone"}, bus.res_none, 0);
        check_val({tag, "_rshort"}, bus.res_short, 0);
        check_val({tag, "_eund"}, bus.err_underrun, 0);
        check_val({tag, "_ewr"}, bus.err_wr_busy, 0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rstn = 1'b0;
        bus.wr_en = 1'b0;
        bus.wr_slot = '0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.load_done = 1'b0;
        bus.cnn_din_ready = 1'b0;
        bus.cnn_conv1_done = 1'b0;
        bus.cnn_done = 1'b0;
        bus.cnn_classes = '0;
        tick();
        tick();
        check_zero("reset");
        rstn = 1'b1;
        tick();

        // Single image, pixel i = i, then an extra request past the end.
        load_px(0, NP, 0);
        mark_full(0);
        check_val("t1_full", bus.slot_full, 2'b01);
        check_val("t1_idle", bus.busy, 0);
        tick();
        check_val("t1_busy", bus.busy, 1);
        stream_px(NP, 0, 1'b0, 0, 1'b1);
        check_val("t1_no_underrun", bus.err_underrun, 0);
        bus.cnn_din_ready = 1'b1;
        tick();
        bus.cnn_din_ready = 1'b0;
        check_val("t1_underrun_hold", bus.cnn_din, 783);
        check_val("t1_underrun", bus.err_underrun, 1);
        finish_img(10'b0000100000, 0, 5, 0, 0, 1'b1);
        check_val("t1_empty", bus.slot_full, 0);
        check_val("t1_no_wrerr", bus.err_wr_busy, 0);

        // Two slots back-to-back; slot1 loaded while slot0 streams.
        load_px(0, NP, 1000);
        mark_full(0);
        tick();
        bus.wr_en = 1'b1;
        bus.wr_slot = SW'(0);
        bus.wr_addr = AW'(5);
        bus.wr_data = 32'hdead;
        tick();
        bus.wr_en = 1'b0;
        check_val("t3_wr_busy", bus.err_wr_busy, 1);
        stream_px(NP, 1000, 1'b1, 2000, 1'b0);
        mark_full(1);
        check_val("t2_both_full", bus.slot_full, 2'b11);
        finish_img(10'b1000000000, 0, 9, 0, 0, 1'b1);
        check_val("t2_slot1_left", bus.slot_full, 2'b10);
        tick();
        check_val("t2_busy1", bus.busy, 1);
        stream_px(NP, 2000, 1'b0, 0, 1'b0);
        finish_img(10'b0000000011, 1, 0, 0, 0, 1'b1);
        check_val("t2_empty", bus.slot_full, 0);

        // Early done with an empty class vector; pointer wraps to slot1.
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        check_val("t5_eund_clr", bus.err_underrun, 0);
        check_val("t5_ewr_clr", bus.err_wr_busy, 0);
        load_px(1, 100, 3000);
        mark_full(1);
        tick();
        check_val("t5_busy", bus.busy, 1);
        stream_px(100, 3000, 1'b0, 0, 1'b0);
        finish_img('0, 1, 0, 1, 1, 1'b0);
        tick();
        check_val("t5_still_idle", bus.busy, 0);
        check_val("t5_empty", bus.slot_full, 0);

        // Reset mid-stream, then a fresh image streams from pixel 0.
        load_px(0, 60, 4000);
        mark_full(0);
        tick();
        stream_px(50, 4000, 1'b0, 0, 1'b0);
        bus.wr_en = 1'b1;
        bus.wr_slot = SW'(0);
        bus.wr_addr = AW'(3);
        tick();
        bus.wr_en = 1'b0;
        check_val("t6_wr_busy", bus.err_wr_busy, 1);
        rstn = 1'b0;
        tick();
        check_zero("midrst");
        rstn = 1'b1;
        load_px(0, 20, 5000);
        mark_full(0);
        tick();
        check_val("t6_busy", bus.busy, 1);
        stream_px(20, 5000, 1'b0, 0, 1'b0);
        finish_img(10'b0100000000, 0, 8, 0, 1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
